// File: rtl/gpc_pipe_accum_if.sv
// Handshake and data bundle for the gpc_pipe_accum streaming counter.
// The master drives beats and consumes results; the slave is the counter itself.
interface gpc_pipe_accum_if #(
   parameter int NCOL   = 4,
   parameter int HEIGHT = 5,
   parameter int ACCW   = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [NCOL*HEIGHT-1:0] src;
   logic                   mode;
   logic                   acc_clr;
   logic                   out_valid;
   logic                   out_ready;
   logic [ACCW-1:0]        dst;
   logic                   ovf;

   modport master (
      output in_valid, src, mode, acc_clr, out_ready,
      input  in_ready, out_valid, dst, ovf
   );

   modport slave (
      input  in_valid, src, mode, acc_clr, out_ready,
      output in_ready, out_valid, dst, ovf
   );
endinterface

// File: rtl/gpc_pipe_accum.sv
// Three-stage pipelined generalised parallel counter with valid/ready handshake
// and an optional wrapping accumulator with a sticky overflow flag.
module gpc_pipe_accum #(
   parameter int NCOL   = 4,
   parameter int HEIGHT = 5,
   parameter int ACCW   = 16
) (
   input logic             clk,
   input logic             rst_n,
   gpc_pipe_accum_if.slave bus
);
   localparam int SUMW = $clog2(HEIGHT * ((1 << NCOL) - 1) + 1);
   localparam int PCW  = $clog2(HEIGHT + 1);

   if (ACCW < SUMW) begin : g_accw_chk
      $error("gpc_pipe_accum: ACCW (%0d) must be >= SUMW (%0d)", ACCW, SUMW);
   end

   function automatic logic [PCW-1:0] popcnt(input logic [HEIGHT-1:0] v);
      logic [PCW-1:0] n;
      n = {PCW{1'b0}};
      for (int i = 0; i < HEIGHT; i++) begin
         n = n + PCW'(v[i]);
      end
      return n;
   endfunction

   logic                r_live;
   logic                r_s1_vld;
   logic                r_s1_mode;
   logic [PCW-1:0]      r_s1_pc [NCOL];
   logic                r_s2_vld;
   logic                r_s2_mode;
   logic [SUMW-1:0]     r_s2_sum;
   logic                r_out_vld;
   logic [ACCW-1:0]     r_dst;
   logic [ACCW-1:0]     r_acc;
   logic                r_ovf;

   logic                w_en;
   logic [PCW-1:0]      w_pc [NCOL];
   logic [SUMW-1:0]     w_wsum;
   logic [ACCW-1:0]     w_sum_ext;
   logic [ACCW-1:0]     w_acc_base;
   logic                w_ovf_base;
   logic [ACCW:0]       w_add;

   // r_live holds in_ready low until the first edge after reset release.
   assign w_en          = r_live & (~r_out_vld | bus.out_ready);
   assign bus.in_ready  = w_en;
   assign bus.out_valid = r_out_vld;
   assign bus.dst       = r_dst;
   assign bus.ovf       = r_ovf;

   // Per-column popcounts of the incoming beat.
   always_comb begin
      for (int c = 0; c < NCOL; c++) begin
         w_pc[c] = popcnt(bus.src[c*HEIGHT +: HEIGHT]);
      end
   end

   // Weighted sum of registered popcounts plus clear-then-add accumulator path.
   always_comb begin
      w_wsum = {SUMW{1'b0}};
      for (int c = 0; c < NCOL; c++) begin
         w_wsum = w_wsum + (SUMW'(r_s1_pc[c]) << c);
      end
      w_sum_ext = ACCW'(r_s2_sum);
      if (bus.acc_clr) begin
         w_acc_base = {ACCW{1'b0}};
         w_ovf_base = 1'b0;
      end else begin
         w_acc_base = r_acc;
         w_ovf_base = r_ovf;
      end
      w_add = {1'b0, w_acc_base} + {1'b0, w_sum_ext};
   end

   // Stages 1 and 2: popcount and weighted-sum registers, frozen when en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live    <= 1'b0;
         r_s1_vld  <= 1'b0;
         r_s1_mode <= 1'b0;
         for (int c = 0; c < NCOL; c++) begin
            r_s1_pc[c] <= {PCW{1'b0}};
         end
         r_s2_vld  <= 1'b0;
         r_s2_mode <= 1'b0;
         r_s2_sum  <= {SUMW{1'b0}};
      end else begin
         r_live <= 1'b1;
         if (w_en) begin
            r_s1_vld  <= bus.in_valid;
            r_s1_mode <= bus.mode;
            for (int c = 0; c < NCOL; c++) begin
               r_s1_pc[c] <= w_pc[c];
            end
            r_s2_vld  <= r_s1_vld;
            r_s2_mode <= r_s1_mode;
            r_s2_sum  <= w_wsum;
         end
      end
   end

   // Stage 3: commit to dst, update accumulator and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld <= 1'b0;
         r_dst     <= {ACCW{1'b0}};
         r_acc     <= {ACCW{1'b0}};
         r_ovf     <= 1'b0;
      end else if (w_en && r_s2_vld) begin
         r_out_vld <= 1'b1;
         if (r_s2_mode) begin
            r_acc <= w_add[ACCW-1:0];
            r_dst <= w_add[ACCW-1:0];
            r_ovf <= w_ovf_base | w_add[ACCW];
         end else begin
            r_dst <= w_sum_ext;
            r_acc <= w_acc_base;
            r_ovf <= w_ovf_base;
         end
      end else begin
         if (w_en) begin
            r_out_vld <= 1'b0;
         end
         r_acc <= w_acc_base;
         r_ovf <= w_ovf_base;
      end
   end
endmodule

// File: tb/tb_gpc_pipe_accum.sv
// Directed bench for gpc_pipe_accum (NCOL=4, HEIGHT=5, ACCW=8).
module tb_gpc_pipe_accum;
   localparam logic [19:0] FULL = 20'hFFFFF;

   logic clk;
   logic rst_n;
   int   n_err;
   int   n_chk;
   int   idx;
   logic w_rdy;

   logic [19:0] sv [8];
   logic        sm [8];
   logic [7:0]  se [8];
   logic        sf [8];
   logic [19:0] bp [5];

   gpc_pipe_accum_if #(.NCOL(4), .HEIGHT(5), .ACCW(8)) bus ();

   gpc_pipe_accum #(.NCOL(4), .HEIGHT(5), .ACCW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_beat(input int i, input logic [19:0] s, input logic m,
                           input logic [7:0] e, input logic f);
      sv[i] = s; sm[i] = m; se[i] = e; sf[i] = f;
   endtask

   // Back-to-back beats with out_ready high; each result is due 3 edges after its beat.
   task automatic stream(input int n);
      for (int i = 0; i < n + 2; i++) begin
         if (i < n) begin
            bus.in_valid = 1'b1;
            bus.src      = sv[i];
            bus.mode     = sm[i];
         end else begin
            bus.in_valid = 1'b0;
         end
         tick();
         if (i >= 2) begin
            chk("stream_vld", {31'd0, bus.out_valid}, 32'd1);
            chk("stream_dst", {24'd0, bus.dst}, {24'd0, se[i-2]});
            chk("stream_ovf", {31'd0, bus.ovf}, {31'd0, sf[i-2]});
         end
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      n_err = 0;
      n_chk = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.src       = 20'h00000;
      bus.mode      = 1'b0;
      bus.acc_clr   = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_dst", {24'd0, bus.dst}, 32'd0);
      chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Full scale, pass mode, exact 3-cycle latency.
      bus.in_valid = 1'b1;
      bus.src      = FULL;
      bus.mode     = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      chk("t1_lat1", {31'd0, bus.out_valid}, 32'd0);
      tick();
      chk("t1_lat2", {31'd0, bus.out_valid}, 32'd0);
      tick();
      chk("t1_vld", {31'd0, bus.out_valid}, 32'd1);
      chk("t1_dst", {24'd0, bus.dst}, 32'h4B);
      tick();
      chk("t1_bubble", {31'd0, bus.out_valid}, 32'd0);
      chk("t1_hold", {24'd0, bus.dst}, 32'h4B);

      // Mixed weights.
      set_beat(0, {5'h01, 5'h01, 5'h04, 5'h0b}, 1'b0, 8'h11, 1'b0);
      set_beat(1, {5'h03, 5'h00, 5'h02, 5'h10}, 1'b0, 8'h13, 1'b0);
      stream(2);
      tick();

      // Accumulate with wrap at ACCW=8.
      for (int i = 0; i < 4; i++) set_beat(i, FULL, 1'b1, 8'(75 * (i + 1)), (i == 3));
      stream(4);
      tick();
      chk("t3_ovf_sticky", {31'd0, bus.ovf}, 32'd1);
      chk("t3_idle", {31'd0, bus.out_valid}, 32'd0);

      // Bring acc to 100 (44 + 56), then clear coincident with a sum-20 accumulate.
      set_beat(0, {5'h1f, 5'h0f, 5'h00, 5'h00}, 1'b1, 8'd100, 1'b1);
      stream(1);
      bus.in_valid = 1'b1;
      bus.src      = {5'h00, 5'h1f, 5'h00, 5'h00};
      bus.mode     = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.acc_clr = 1'b1;
      tick();
      bus.acc_clr = 1'b0;
      chk("t5_clr_vld", {31'd0, bus.out_valid}, 32'd1);
      chk("t5_clr_dst", {24'd0, bus.dst}, 32'd20);
      chk("t5_clr_ovf", {31'd0, bus.ovf}, 32'd0);
      set_beat(0, 20'h00001, 1'b1, 8'd21, 1'b0);
      stream(1);
      bus.acc_clr = 1'b1;
      tick();
      bus.acc_clr = 1'b0;
      chk("t5_clr_alone_dst", {24'd0, bus.dst}, 32'd21);
      chk("t5_clr_alone_vld", {31'd0, bus.out_valid}, 32'd0);
      set_beat(0, 20'h00007, 1'b1, 8'd3, 1'b0);
      set_beat(1, FULL, 1'b0, 8'd75, 1'b0);
      set_beat(2, 20'h00001, 1'b1, 8'd4, 1'b0);
      stream(3);
      tick();

      // Backpressure: five beats offered, three fit before the pipe freezes.
      bp[0] = 20'h00001; bp[1] = 20'h00003; bp[2] = 20'h00007;
      bp[3] = 20'h0000F; bp[4] = 20'h0001F;
      bus.out_ready = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         bus.in_valid = 1'b1;
         bus.src      = bp[idx];
         bus.mode     = 1'b0;
         w_rdy        = bus.in_ready;
         tick();
         if (w_rdy) idx++;
      end
      bus.in_valid = 1'b0;
      chk("t4_accepted", 32'(idx), 32'd3);
      chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t4_vld", {31'd0, bus.out_valid}, 32'd1);
      chk("t4_dst0", {24'd0, bus.dst}, 32'd1);
      tick();
      tick();
      chk("t4_frozen_dst", {24'd0, bus.dst}, 32'd1);
      chk("t4_frozen_vld", {31'd0, bus.out_valid}, 32'd1);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.src       = bp[3];
      tick();
      chk("t4_dst1", {24'd0, bus.dst}, 32'd2);
      bus.src = bp[4];
      tick();
      bus.in_valid = 1'b0;
      chk("t4_dst2", {24'd0, bus.dst}, 32'd3);
      tick();
      chk("t4_dst3", {24'd0, bus.dst}, 32'd4);
      tick();
      chk("t4_dst4", {24'd0, bus.dst}, 32'd5);
      chk("t4_dst4_vld", {31'd0, bus.out_valid}, 32'd1);
      tick();
      chk("t4_drained", {31'd0, bus.out_valid}, 32'd0);

      // Reset mid-operation: acc=4 -> 79,154,229,48 (wrap), then freeze with 123 showing.
      for (int i = 0; i < 4; i++) set_beat(i, FULL, 1'b1, 8'(4 + 75 * (i + 1)), (i == 3));
      stream(4);
      tick();
      bus.out_ready = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         bus.in_valid = 1'b1;
         bus.src      = FULL;
         bus.mode     = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("t6_pre_vld", {31'd0, bus.out_valid}, 32'd1);
      chk("t6_pre_dst", {24'd0, bus.dst}, 32'd123);
      chk("t6_pre_ovf", {31'd0, bus.ovf}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_vld", {31'd0, bus.out_valid}, 32'd0);
      chk("t6_rst_dst", {24'd0, bus.dst}, 32'd0);
      chk("t6_rst_ovf", {31'd0, bus.ovf}, 32'd0);
      #2;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         tick();
         chk("t6_no_stale", {31'd0, bus.out_valid}, 32'd0);
      end
      set_beat(0, 20'h00001, 1'b1, 8'd1, 1'b0);
      stream(1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
